decode_issue: RTL
=================

// Module: decode_issue
// PURPOSE
// - Decode/issue stage directly upstream of the 8x16 register file. Accepts 16-bit
//   instructions from fetch (valid/ready), decodes them into register selects,
//   write enable and immediate, and holds the result in one output register.
// - An 8-bit pending-write scoreboard stalls issue on RAW/WAW hazards. Entries clear
//   on writeback from the downstream execute/writeback path.
// PARAMETERS
// - DATA_W   16  immediate/data width; O_imm is sign-extended to this width
// - SEL_W    3   register select width; NREGS = 2**SEL_W scoreboard bits
// PORTS
// - I_clk        in   1       clock; all state updates on posedge
// - I_rst        in   1       synchronous, active-high reset
// - I_en         in   1       stage enable; 0 = freeze accept and output register
// - I_inst_valid in   1       fetch presents I_inst
// - I_inst       in   16      [15:12] op, [11:9] rD, [7:5] rA, [4:2] rB, [7:0] imm8
// - O_inst_ready out  1       stage accepts I_inst this cycle
// - O_valid      out  1       decoded instruction valid
// - I_ready      in   1       downstream consumes the output this cycle
// - O_opcode     out  4       registered opcode
// - O_selA/B/D   out  SEL_W   register-file selects (0 when the field is unused)
// - O_we         out  1       instruction writes rD
// - O_imm        out  DATA_W  sign-extended imm8
// - O_use_imm    out  1       operand B comes from O_imm
// - O_illegal    out  1       decoded opcode is reserved
// - I_wb_valid   in   1       writeback completed this cycle
// - I_wb_sel     in   SEL_W   register written back
// - O_stall      out  1       I_inst_valid && hazard
// BEHAVIOUR
// - Op classes: 0x0-0x7 ALU (reads A,B; writes D); 0x8 LI (writes D, use_imm=1);
//   0x9 LD (reads A; writes D); 0xA ST (reads A,B); 0xB BR (reads A);
//   0xC-0xE illegal (no reads, we=0, O_illegal=1); 0xF NOP (no reads, we=0).
// - hazard = pending[rA] for A readers | pending[rB] for B readers | pending[rD] if we.
// - O_inst_ready = I_en & (~O_valid | I_ready) & ~hazard. This is combinational from I_inst.
// - accept = I_inst_valid & O_inst_ready. On accept, the output register loads the
//   decode and O_valid=1. Latency is 1 cycle from accept to O_valid.
// - If O_valid & I_ready & ~accept, then O_valid goes to 0. Outputs hold while
//   O_valid & ~I_ready. Back-to-back issue gives 1 instruction/cycle.
// - Scoreboard: on accept with we=1, set pending[rD]. On I_wb_valid, clear
//   pending[I_wb_sel]. Both on the same register in the same cycle: set wins.
// - Scoreboard clears still apply when I_en=0; only accept and output are frozen.
// - Writeback of a register that is not pending has no effect.
// - Reset: O_valid, O_opcode, O_sel*, O_we, O_imm, O_use_imm, O_illegal = 0;
//   pending = 0. Reset mid-operation drops the held instruction and all pending bits.
//   Fetch must replay.
// - Illegal and NOP instructions are issued normally and never set the scoreboard.
// CONFIGURATION
// - DECODE_WB_BYPASS_EN defined:
//   - hazard masks pending[I_wb_sel] when I_wb_valid in the same cycle.
//   - A dependent instruction therefore issues in the writeback cycle.
// - DECODE_WB_BYPASS_EN undefined:
//   - hazard uses the registered pending only.
//   - A dependent instruction issues one cycle after writeback.
// TESTING
// - Reset, then I_inst=0x1234 valid, I_ready=1
//   -> next cycle O_valid=1, opcode=1, selD=1, selA=1, selB=5, we=1, pending=0x02.
// - Issue 0x1234, then 0x2420 (reads r1)
//   -> O_stall=1, O_inst_ready=0 until I_wb_valid, I_wb_sel=1.
//   - Issue is in the writeback cycle with the macro, one cycle later without it.
// - I_ready=0 for 3 cycles with O_valid=1 -> outputs stable, O_inst_ready=0, no new accept.
// - 0x8A80 (LI r5, 0x80) -> O_imm=0xFF80, use_imm=1, we=1, pending[5]=1.
// - 0xD000 -> O_illegal=1, we=0, pending unchanged.
//   - 0xF000 -> we=0, no stall even with all pending bits set.
// - Same-cycle accept of a writer to r3 with I_wb_valid, I_wb_sel=3 -> pending[3]=1.
//   - I_rst mid-stall -> pending=0, O_valid=0.

Source files
------------

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes 16-bit instructions into register-file selects and tracks pending writes in a scoreboard.
// Optional DECODE_WB_BYPASS_EN: a same-cycle writeback masks its pending bit during hazard checks.
module decode_issue #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SEL_W  = 3
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_en,
    input  logic              I_inst_valid,
    input  logic [15:0]       I_inst,
    output logic              O_inst_ready,
    output logic              O_valid,
    input  logic              I_ready,
    output logic [3:0]        O_opcode,
    output logic [SEL_W-1:0]  O_selA,
    output logic [SEL_W-1:0]  O_selB,
    output logic [SEL_W-1:0]  O_selD,
    output logic              O_we,
    output logic [DATA_W-1:0] O_imm,
    output logic              O_use_imm,
    output logic              O_illegal,
    input  logic              I_wb_valid,
    input  logic [SEL_W-1:0]  I_wb_sel,
    output logic              O_stall
);

    localparam int unsigned NREGS = 2 ** SEL_W;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LI,
        CLS_LD,
        CLS_ST,
        CLS_BR,
        CLS_ILL,
        CLS_NOP
    } op_cls_e;

    op_cls_e            cls;
    logic [3:0]         op;
    logic [SEL_W-1:0]   f_a, f_b, f_d;
    logic               rd_a, rd_b, wr, use_imm, illegal;
    logic [NREGS-1:0]   wb_mask, pend_eff;
    logic               hazard, accept;
    logic               unused_inst_bit;

    logic [NREGS-1:0]   pending_q, pending_d;
    logic               valid_q, valid_d;
    logic [3:0]         opcode_q, opcode_d;
    logic [SEL_W-1:0]   sel_a_q, sel_a_d, sel_b_q, sel_b_d, sel_d_q, sel_d_d;
    logic               we_q, we_d, use_imm_q, use_imm_d, illegal_q, illegal_d;
    logic [DATA_W-1:0]  imm_q, imm_d;

    assign op              = I_inst[15:12];
    assign f_d             = SEL_W'(I_inst[11:9]);
    assign f_a             = SEL_W'(I_inst[7:5]);
    assign f_b             = SEL_W'(I_inst[4:2]);
    assign unused_inst_bit = I_inst[8];

    always_comb begin
        cls = CLS_NOP;
        if (!op[3]) begin
            cls = CLS_ALU;
        end else begin
            case (op[2:0])
                3'h0:    cls = CLS_LI;
                3'h1:    cls = CLS_LD;
                3'h2:    cls = CLS_ST;
                3'h3:    cls = CLS_BR;
                3'h7:    cls = CLS_NOP;
                default: cls = CLS_ILL;
            endcase
        end
    end

    always_comb begin
        rd_a    = 1'b0;
        rd_b    = 1'b0;
        wr      = 1'b0;
        use_imm = 1'b0;
        illegal = 1'b0;
        case (cls)
            CLS_ALU: begin rd_a = 1'b1; rd_b = 1'b1; wr = 1'b1; end
            CLS_LI:  begin wr = 1'b1; use_imm = 1'b1; end
            CLS_LD:  begin rd_a = 1'b1; wr = 1'b1; end
            CLS_ST:  begin rd_a = 1'b1; rd_b = 1'b1; end
            CLS_BR:  rd_a = 1'b1;
            CLS_ILL: illegal = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        wb_mask = '0;
        if (I_wb_valid) wb_mask[I_wb_sel] = 1'b1;
`ifdef DECODE_WB_BYPASS_EN
        pend_eff = pending_q & ~wb_mask;
`else
        pend_eff = pending_q;
`endif
    end

    assign hazard       = (rd_a & pend_eff[f_a]) | (rd_b & pend_eff[f_b]) | (wr & pend_eff[f_d]);
    assign O_inst_ready = I_en & (~valid_q | I_ready) & ~hazard;
    assign O_stall      = I_inst_valid & hazard;
    assign accept       = I_inst_valid & O_inst_ready;

    always_comb begin
        // Clear before set so a same-cycle accept of a writer to the written-back register leaves it pending.
        pending_d = pending_q & ~wb_mask;
        if (accept && wr) pending_d[f_d] = 1'b1;

        valid_d   = valid_q;
        opcode_d  = opcode_q;
        sel_a_d   = sel_a_q;
        sel_b_d   = sel_b_q;
        sel_d_d   = sel_d_q;
        we_d      = we_q;
        imm_d     = imm_q;
        use_imm_d = use_imm_q;
        illegal_d = illegal_q;
        if (accept) begin
            valid_d   = 1'b1;
            opcode_d  = op;
            sel_a_d   = rd_a ? f_a : '0;
            sel_b_d   = rd_b ? f_b : '0;
            sel_d_d   = wr ? f_d : '0;
            we_d      = wr;
            imm_d     = {{(DATA_W-8){I_inst[7]}}, I_inst[7:0]};
            use_imm_d = use_imm;
            illegal_d = illegal;
        end else if (I_en && valid_q && I_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            sel_a_q   <= '0;
            sel_b_q   <= '0;
            sel_d_q   <= '0;
            we_q      <= 1'b0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
            sel_d_q   <= sel_d_d;
            we_q      <= we_d;
            imm_q     <= imm_d;
            use_imm_q <= use_imm_d;
            illegal_q <= illegal_d;
        end
    end

    assign O_valid   = valid_q;
    assign O_opcode  = opcode_q;
    assign O_selA    = sel_a_q;
    assign O_selB    = sel_b_q;
    assign O_selD    = sel_d_q;
    assign O_we      = we_q;
    assign O_imm     = imm_q;
    assign O_use_imm = use_imm_q;
    assign O_illegal = illegal_q;

endmodule
